// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM state encoding
// and the beat-counter width derived from the line size.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } arb_state_e;

  // Width of a counter that indexes the words of one cache line.
  function automatic int beat_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-port signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WORDS = 4
);
  // I-cache refill path
  logic                             i_readM;
  logic [ADDR_WIDTH-1:0]            i_address;
  logic [WORD_WIDTH*LINE_WORDS-1:0] i_data;
  logic                             complete1;
  // D-cache refill / write-back path
  logic                             d_readM;
  logic                             d_writeM;
  logic [ADDR_WIDTH-1:0]            d_address;
  logic [WORD_WIDTH*LINE_WORDS-1:0] d_wdata;
  logic [WORD_WIDTH*LINE_WORDS-1:0] d_data;
  logic                             complete2;
  // Off-chip memory port
  logic                             mem_read;
  logic                             mem_write;
  logic [ADDR_WIDTH-1:0]            mem_address;
  logic [WORD_WIDTH-1:0]            mem_wdata;
  logic [WORD_WIDTH-1:0]            mem_rdata;
  logic                             mem_ack;

  modport slave (
    input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
           mem_rdata, mem_ack,
    output i_data, complete1, d_data, complete2,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
           mem_rdata, mem_ack,
    input  i_data, complete1, d_data, complete2,
           mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_line_buffer.sv
// Line assembly for read bursts (slot-indexed word capture, per-side line hold)
// and word selection from the latched write-back line.
module line_buffer
  import mem_arb_pkg::*;
#(
  parameter  int WORD_WIDTH = 16,
  parameter  int LINE_WORDS = 4,
  localparam int BW         = beat_w(LINE_WORDS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_w_i,
  input  logic [WORD_WIDTH*LINE_WORDS-1:0] wline_i,
  input  logic                             wr_en_i,
  input  logic [BW-1:0]                    slot_i,
  input  logic [WORD_WIDTH-1:0]            word_i,
  input  logic                             commit_i_i,
  input  logic                             commit_d_i,
  output logic [WORD_WIDTH-1:0]            wword_o,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] i_line_o,
  output logic [WORD_WIDTH*LINE_WORDS-1:0] d_line_o
);

  typedef logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] line_t;

  line_t acc_q, acc_d;
  line_t wline_q;
  line_t i_line_q;
  line_t d_line_q;

  // NOTE: acc_d gets its default before the conditional write so every path assigns it and no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (wr_en_i) acc_d[slot_i] = word_i;
  end

  // NOTE: the line holders are plain flops rather than a RAM array, so they can be cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      wline_q  <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      acc_q <= acc_d;
      if (load_w_i)   wline_q  <= wline_i;
      // Commit includes the word arriving with the final ack.
      if (commit_i_i) i_line_q <= acc_d;
      if (commit_d_i) d_line_q <= acc_d;
    end
  end

  assign wword_o  = wline_q[slot_i];
  assign i_line_o = i_line_q;
  assign d_line_o = d_line_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/write-backs,
// running each grant as a LINE_WORDS-beat burst with a one-cycle completion pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int                    BW        = beat_w(LINE_WORDS);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(LINE_WORDS - 1);

  arb_state_e            state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  cpl1_q, cpl1_d;
  logic                  cpl2_q, cpl2_d;
  logic                  grant_w;
  logic                  beat_ack;
  logic                  last_ack;
  logic [WORD_WIDTH-1:0] wword;

  assign beat_ack = bus.mem_ack && (state_q != IDLE);
  assign last_ack = beat_ack && (beat_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      cpl1_q  <= 1'b0;
      cpl2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      cpl1_q  <= cpl1_d;
      cpl2_q  <= cpl2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    cpl1_d  = 1'b0;
    cpl2_d  = 1'b0;
    grant_w = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        // A side whose complete is high is still holding its old request; skip it.
        if (bus.d_writeM && !cpl2_q) begin
          state_d = D_WR;
          base_d  = bus.d_address & ~OFFS_MASK;
          grant_w = 1'b1;
        end else if (bus.d_readM && !cpl2_q) begin
          state_d = D_RD;
          base_d  = bus.d_address & ~OFFS_MASK;
        end else if (bus.i_readM && !cpl1_q) begin
          state_d = I_RD;
          base_d  = bus.i_address & ~OFFS_MASK;
        end
      end
      default: begin
        if (beat_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            cpl1_d  = (state_q == I_RD);
            cpl2_d  = (state_q != I_RD);
          end
        end
      end
    endcase
  end

  line_buffer #(
    .WORD_WIDTH (WORD_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk        (clk),
    .reset      (reset),
    .load_w_i   (grant_w),
    .wline_i    (bus.d_wdata),
    .wr_en_i    (beat_ack && (state_q != D_WR)),
    .slot_i     (beat_q),
    .word_i     (bus.mem_rdata),
    .commit_i_i (last_ack && (state_q == I_RD)),
    .commit_d_i (last_ack && (state_q == D_RD)),
    .wword_o    (wword),
    .i_line_o   (bus.i_data),
    .d_line_o   (bus.d_data)
  );

  assign bus.mem_read    = (state_q == I_RD) || (state_q == D_RD);
  assign bus.mem_write   = (state_q == D_WR);
  assign bus.mem_address = base_q + ADDR_WIDTH'(beat_q);
  assign bus.mem_wdata   = (state_q == D_WR) ? wword : '0;
  assign bus.complete1   = cpl1_q;
  assign bus.complete2   = cpl2_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench-driven memory acks, expected values
// written out by hand for each burst.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .LINE_WORDS(4)) bus ();

  mem_arbiter #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .LINE_WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge where the burst strobe is already up; acks each beat
  // on the gap-th cycle and returns at the negedge where complete is high.
  task automatic serve(input logic wr, input logic [15:0] base,
                       input logic [63:0] words, input int gap);
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < gap; s++) begin
        check(wr ? "wr_strobe" : "rd_strobe",
              64'(wr ? bus.mem_write : bus.mem_read), 64'h1);
        check(wr ? "rd_strobe_off" : "wr_strobe_off",
              64'(wr ? bus.mem_read : bus.mem_write), 64'h0);
        check("beat_addr", 64'(bus.mem_address), 64'(base) + 64'(b));
        if (wr) check("beat_wdata", 64'(bus.mem_wdata), 64'(words[b*16 +: 16]));
        bus.mem_ack   = (s == gap - 1);
        bus.mem_rdata = wr ? 16'h0000 : words[b*16 +: 16];
        tick();
      end
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
  endtask

  initial begin
    bus.i_readM   = 1'b0;
    bus.i_address = '0;
    bus.d_readM   = 1'b0;
    bus.d_writeM  = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    reset         = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_mem_read",  64'(bus.mem_read),    64'h0);
    check("rst_mem_write", 64'(bus.mem_write),   64'h0);
    check("rst_complete1", 64'(bus.complete1),   64'h0);
    check("rst_complete2", 64'(bus.complete2),   64'h0);
    check("rst_mem_addr",  64'(bus.mem_address), 64'h0);
    check("rst_mem_wdata", 64'(bus.mem_wdata),   64'h0);
    check("rst_i_data",    bus.i_data,           64'h0);
    check("rst_d_data",    bus.d_data,           64'h0);
    reset = 1'b0;
    tick();

    // I-only read, unaligned address, ack every cycle
    bus.i_readM   = 1'b1;
    bus.i_address = 16'h0013;
    tick();
    serve(1'b0, 16'h0010, 64'h00A3_00A2_00A1_00A0, 1);
    check("t1_complete1", 64'(bus.complete1), 64'h1);
    check("t1_complete2", 64'(bus.complete2), 64'h0);
    check("t1_strobe_drop", 64'(bus.mem_read), 64'h0);
    check("t1_i_data", bus.i_data, 64'h00A3_00A2_00A1_00A0);
    bus.i_readM = 1'b0;
    tick();
    check("t1_complete1_pulse", 64'(bus.complete1), 64'h0);
    check("t1_idle", 64'(bus.mem_read), 64'h0);

    // Ack while idle is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_ack   = 1'b0;
    check("idle_ack_read",  64'(bus.mem_read),  64'h0);
    check("idle_ack_write", 64'(bus.mem_write), 64'h0);

    // Simultaneous I and D reads: D first, I granted in the complete2 cycle
    bus.i_readM   = 1'b1;
    bus.i_address = 16'h0020;
    bus.d_readM   = 1'b1;
    bus.d_address = 16'h0040;
    tick();
    serve(1'b0, 16'h0040, 64'h00B3_00B2_00B1_00B0, 1);
    check("t2_complete2", 64'(bus.complete2), 64'h1);
    check("t2_no_complete1", 64'(bus.complete1), 64'h0);
    check("t2_d_data", bus.d_data, 64'h00B3_00B2_00B1_00B0);
    bus.d_readM = 1'b0;
    tick();
    check("t2_complete2_pulse", 64'(bus.complete2), 64'h0);
    serve(1'b0, 16'h0020, 64'h00C3_00C2_00C1_00C0, 1);
    check("t2_complete1", 64'(bus.complete1), 64'h1);
    check("t2_i_data", bus.i_data, 64'h00C3_00C2_00C1_00C0);
    check("t2_d_data_held", bus.d_data, 64'h00B3_00B2_00B1_00B0);
    bus.i_readM = 1'b0;
    tick();

    // Write-back with ack every third cycle
    bus.d_writeM  = 1'b1;
    bus.d_address = 16'h0080;
    bus.d_wdata   = 64'h4444_3333_2222_1111;
    tick();
    serve(1'b1, 16'h0080, 64'h4444_3333_2222_1111, 3);
    check("t3_complete2", 64'(bus.complete2), 64'h1);
    check("t3_write_drop", 64'(bus.mem_write), 64'h0);
    check("t3_d_data_kept", bus.d_data, 64'h00B3_00B2_00B1_00B0);
    bus.d_writeM = 1'b0;
    tick();
    check("t3_complete2_pulse", 64'(bus.complete2), 64'h0);
    check("t3_no_extra_beat", 64'(bus.mem_write), 64'h0);
    tick();
    check("t3_still_idle", 64'(bus.mem_write), 64'h0);

    // Read and write together: write first, read after it is re-presented
    bus.d_readM   = 1'b1;
    bus.d_writeM  = 1'b1;
    bus.d_address = 16'h0091;
    bus.d_wdata   = 64'h0D0C_0B0A_0908_0706;
    tick();
    serve(1'b1, 16'h0090, 64'h0D0C_0B0A_0908_0706, 1);
    check("t4_complete2_wr", 64'(bus.complete2), 64'h1);
    bus.d_readM  = 1'b0;
    bus.d_writeM = 1'b0;
    tick();
    check("t4_gap_read",  64'(bus.mem_read),  64'h0);
    check("t4_gap_write", 64'(bus.mem_write), 64'h0);
    bus.d_readM = 1'b1;
    tick();
    serve(1'b0, 16'h0090, 64'h00D3_00D2_00D1_00D0, 2);
    check("t4_complete2_rd", 64'(bus.complete2), 64'h1);
    check("t4_d_data", bus.d_data, 64'h00D3_00D2_00D1_00D0);
    bus.d_readM = 1'b0;
    tick();

    // Reset after beat 1 of an I read, then a fresh burst from beat 0
    bus.i_readM   = 1'b1;
    bus.i_address = 16'h0030;
    tick();
    check("t5_beat0_addr", 64'(bus.mem_address), 64'h0030);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h00E0;
    tick();
    check("t5_beat1_addr", 64'(bus.mem_address), 64'h0031);
    bus.mem_rdata = 16'h00E1;
    tick();
    bus.mem_ack = 1'b0;
    check("t5_beat2_addr", 64'(bus.mem_address), 64'h0032);
    reset = 1'b1;
    tick();
    check("t5_rst_read",      64'(bus.mem_read),    64'h0);
    check("t5_rst_complete1", 64'(bus.complete1),   64'h0);
    check("t5_rst_addr",      64'(bus.mem_address), 64'h0);
    check("t5_rst_i_data",    bus.i_data,           64'h0);
    reset = 1'b0;
    tick();
    serve(1'b0, 16'h0030, 64'h00F3_00F2_00F1_00F0, 1);
    check("t5_complete1", 64'(bus.complete1), 64'h1);
    check("t5_i_data", bus.i_data, 64'h00F3_00F2_00F1_00F0);

    // Request held through complete1: no regrant that cycle, regrant next
    tick();
    check("t6_no_regrant", 64'(bus.mem_read), 64'h0);
    check("t6_complete1_pulse", 64'(bus.complete1), 64'h0);
    tick();
    check("t6_regrant", 64'(bus.mem_read), 64'h1);
    // Dropping the request mid-burst must not abort it
    bus.i_readM = 1'b0;
    serve(1'b0, 16'h0030, 64'h0063_0062_0061_0060, 1);
    check("t6_complete1", 64'(bus.complete1), 64'h1);
    check("t6_i_data", bus.i_data, 64'h0063_0062_0061_0060);
    tick();
    check("t6_idle", 64'(bus.mem_read), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the instruction-cache refill path (i_readM) and the data-cache refill/write-back path (d_readM, d_writeM).
- Sequences each granted request as a LINE_WORDS-beat word burst, assembles or splits cache lines, and returns one-cycle completion pulses.
- complete1 serves the I-side and complete2 the D-side; the hazard unit consumes both to release pipeline stalls.
- Sits between the two caches and the memory model.

Parameters:
- WORD_WIDTH, 16, bits per memory word.
- ADDR_WIDTH, 16, word-address width.
- LINE_WORDS, 4, words per cache line; power of two, 2..8.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_readM  in  1  I-cache line-read request, held until complete1.
- i_address  in  ADDR_WIDTH  I-side line base address (low log2(LINE_WORDS) bits ignored).
- i_data  out  WORD_WIDTH*LINE_WORDS  I-side refill line, word 0 in LSBs.
- complete1  out  1  one-cycle pulse, I-side line done.
- d_readM  in  1  D-cache line-read request.
- d_writeM  in  1  D-cache line write-back request.
- d_address  in  ADDR_WIDTH  D-side line base address.
- d_wdata  in  WORD_WIDTH*LINE_WORDS  write-back line, held stable while d_writeM is high.
- d_data  out  WORD_WIDTH*LINE_WORDS  D-side refill line.
- complete2  out  1  one-cycle pulse, D-side read or write done.
- mem_read  out  1  memory word read strobe.
- mem_write  out  1  memory word write strobe.
- mem_address  out  ADDR_WIDTH  word address of current beat.
- mem_wdata  out  WORD_WIDTH  current write word.
- mem_rdata  in  WORD_WIDTH  read word, valid with mem_ack.
- mem_ack  in  1  beat accepted/returned; any latency of 1 or more cycles.

Behaviour:
- Reset values: state IDLE, beat counter 0, mem_read/mem_write/complete1/complete2 0, mem_address 0, mem_wdata 0, i_data/d_data 0. Reset mid-burst aborts the burst silently: no complete pulse, partial line discarded.
- FSM states:
  - IDLE.
  - I_RD.
  - D_RD.
  - D_WR.
- IDLE arbitration, evaluated each cycle, fixed priority:
  - d_writeM goes to D_WR.
  - else d_readM goes to D_RD.
  - else i_readM goes to I_RD.
  - Data side wins because it belongs to the older instruction in the pipeline.
  - If d_readM and d_writeM are both high, the write is served first; the read is served after its own arbitration.
- Grant cycle: latches the base address with the low bits zeroed and clears the beat counter. Strobes rise the cycle after grant.
- Burst:
  - mem_read or mem_write stays high for the whole burst.
  - mem_address = base + beat.
  - mem_wdata = word[beat] of the latched d_wdata.
  - Each cycle with mem_ack high: read data goes into line slot[beat] and beat increments.
  - Counter is log2(LINE_WORDS) bits; beats past LINE_WORDS-1 are never issued.
- Finish:
  - The ack of beat LINE_WORDS-1 drops the strobe the next cycle and returns to IDLE.
  - The matching complete1 or complete2 is high for exactly that one cycle.
  - The assembled line is presented on i_data or d_data and held until the next refill to that side.
- Requester rule: a request must drop in the cycle its complete is high. In that same cycle the arbiter ignores the completing side's request, so there is no duplicate grant. The other side may be granted in that cycle.
- Minimum back-to-back gap between bursts is 1 idle cycle.
- A request deasserted mid-burst does not abort the burst; it completes normally.
- mem_ack while in IDLE is ignored.
- Starvation: the I-side may wait indefinitely while D-side requests keep arriving. This is accepted, because the pipeline stalls on D-side misses.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding constants (IDLE=0, I_RD=1, D_RD=2, D_WR=3);
  - the LINE_WORDS-derived beat-counter width function.
- One natural sub-module, line_buffer: holds the slot-indexed word write, and the line hold for read data plus the word select for write data.
- The FSM and arbitration stay in mem_arbiter.

Test Plan:
- I-only read: i_readM=1, i_address=0x0013, memory returns 0xA0..0xA3 with ack every cycle → mem_address 0x0010..0x0013; complete1 pulses once; i_data = {A3,A2,A1,A0}.
- Simultaneous request: i_readM and d_readM rise together, d_address=0x0040 → D_RD served first and complete2 pulses; I_RD is granted in the complete2 cycle; complete1 follows.
- Write-back with stalls: d_writeM=1, d_address=0x0080, d_wdata={4444,3333,2222,1111}, ack every 3rd cycle → four writes to 0x0080..0x0083 with correct words; one complete2 pulse; no extra beats.
- Read+write conflict: d_readM=d_writeM=1 → write burst first; read burst granted only after the requester re-presents the read following complete2.
- Reset mid-burst: assert reset after beat 1 of an I_RD → next cycle all strobes 0 and state IDLE; no complete1; a fresh request afterward restarts at beat 0.
- Held request: keep i_readM high during the complete1 cycle → no regrant that cycle; regranted the following cycle.
